// File: rtl/uart_packet_parser_if.sv
// Framed packet stream carried from the parser to the register controllers.
// Header fields stay stable for every Valid beat of a packet.
interface uart_packet_parser_if;
    logic       SoP;
    logic       EoP;
    logic [7:0] Destination;
    logic [7:0] Source;
    logic [7:0] Length;
    logic [7:0] Data;
    logic       Valid;

    modport master (
        output SoP, EoP, Destination, Source, Length, Data, Valid
    );

    modport slave (
        input SoP, EoP, Destination, Source, Length, Data, Valid
    );
endinterface

// File: rtl/uart_packet_parser.sv
// Frames the raw UART byte stream (SYNC, DEST, SRC, LEN, data) into packet beats,
// discarding zero-length or stalled frames with a one-cycle error pulse.
module uart_packet_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                        ipClk,
    input  logic                        ipReset,
    input  logic [7:0]                  ipRxData,
    input  logic                        ipRxValid,
    uart_packet_parser_if.master        opRxStream,
    output logic                        opError,
    output logic                        opBusy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DEST = 3'd1;
    localparam logic [2:0] S_SRC  = 3'd2;
    localparam logic [2:0] S_LEN  = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;

    logic [2:0]    r_state;
    logic [7:0]    r_cnt;
    logic [TW-1:0] r_tmo;
    logic          r_valid;
    logic          r_sop;
    logic          r_eop;
    logic          r_error;
    logic [7:0]    r_data;
    logic [7:0]    r_dest;
    logic [7:0]    r_src;
    logic [7:0]    r_len;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_error <= 1'b0;
            r_data  <= '0;
            r_dest  <= '0;
            r_src   <= '0;
            r_len   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_error <= 1'b0;

            // A byte arriving on the terminal count wins: the timeout only fires on idle cycles.
            if (r_state != S_IDLE && !ipRxValid) begin
                if (r_tmo == TMO_LAST) begin
                    r_error <= 1'b1;
                    r_state <= S_IDLE;
                    r_tmo   <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end

            if (ipRxValid) begin
                case (r_state)
                    S_IDLE: begin
                        if (ipRxData == SYNC_BYTE) begin
                            r_state <= S_DEST;
                        end
                    end
                    S_DEST: begin
                        r_dest  <= ipRxData;
                        r_state <= S_SRC;
                    end
                    S_SRC: begin
                        r_src   <= ipRxData;
                        r_state <= S_LEN;
                    end
                    S_LEN: begin
                        if (ipRxData == 8'd0) begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_len   <= ipRxData;
                            r_cnt   <= ipRxData;
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_valid <= 1'b1;
                        r_data  <= ipRxData;
                        r_sop   <= (r_cnt == r_len);
                        r_eop   <= (r_cnt == 8'd1);
                        r_cnt   <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign opRxStream.Valid       = r_valid;
    assign opRxStream.SoP         = r_sop;
    assign opRxStream.EoP         = r_eop;
    assign opRxStream.Data        = r_data;
    assign opRxStream.Destination = r_dest;
    assign opRxStream.Source      = r_src;
    assign opRxStream.Length      = r_len;
    assign opError                = r_error;
    assign opBusy                 = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_packet_parser.sv
// Randomized and directed bench for uart_packet_parser against a queue-based frame model.
module tb_uart_packet_parser;

    localparam int TMO = 20;

    logic       ipClk;
    logic       ipReset;
    logic [7:0] ipRxData;
    logic       ipRxValid;
    logic       opError;
    logic       opBusy;

    uart_packet_parser_if rx_if();

    uart_packet_parser #(
        .SYNC_BYTE      (8'h55),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .ipRxData   (ipRxData),
        .ipRxValid  (ipRxValid),
        .opRxStream (rx_if),
        .opError    (opError),
        .opBusy     (opBusy)
    );

    initial ipClk = 1'b0;
    always #5 ipClk = ~ipClk;

    typedef struct packed {
        logic       valid;
        logic       sop;
        logic       eop;
        logic       err;
        logic       busy;
        logic [7:0] data;
        logic [7:0] dest;
        logic [7:0] src;
        logic [7:0] len;
    } out_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] dest;
        logic [7:0] src;
        logic [7:0] len;
        logic       sop;
        logic       eop;
    } ev_t;

    out_t       exp_cur;
    out_t       exp_nxt;
    logic [7:0] fb[$];
    logic [7:0] bq[$];
    ev_t        ev_q[$];
    int         err_q[$];
    int         gap;
    int         step_no;
    int         checks;
    int         errors;
    logic       chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: collect bytes of the current frame in a queue and read fields by position.
    task automatic model(input logic v, input logic [7:0] d);
        out_t o;
        int   n;
        ev_t  e;
        o       = exp_nxt;
        o.valid = 1'b0;
        o.sop   = 1'b0;
        o.eop   = 1'b0;
        o.err   = 1'b0;
        if (!v) begin
            if (fb.size() != 0) begin
                gap++;
                if (gap == TMO) begin
                    o.err = 1'b1;
                    err_q.push_back(step_no);
                    fb.delete();
                    gap = 0;
                end
            end
        end else begin
            gap = 0;
            if (fb.size() == 0) begin
                if (d == 8'h55) fb.push_back(d);
            end else begin
                fb.push_back(d);
                n = fb.size();
                if (n == 2) o.dest = d;
                if (n == 3) o.src = d;
                if (n == 4) begin
                    if (d == 8'd0) begin
                        o.err = 1'b1;
                        err_q.push_back(step_no);
                        fb.delete();
                    end else begin
                        o.len = d;
                    end
                end
                if (n >= 5) begin
                    o.valid = 1'b1;
                    o.data  = d;
                    o.sop   = (n == 5);
                    o.eop   = (n == 4 + int'(fb[3]));
                    e.data = d; e.dest = o.dest; e.src = o.src; e.len = o.len;
                    e.sop = o.sop; e.eop = o.eop;
                    ev_q.push_back(e);
                    if (o.eop) fb.delete();
                end
            end
        end
        o.busy  = (fb.size() != 0);
        exp_nxt = o;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        @(posedge ipClk);
        #1;
        exp_cur   = exp_nxt;
        ipRxValid = v;
        ipRxData  = d;
        step_no++;
        model(v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send_bq();
        for (int i = 0; i < bq.size(); i++) step(1'b1, bq[i]);
    endtask

    task automatic model_reset();
        fb.delete();
        gap     = 0;
        exp_cur = '0;
        exp_nxt = '0;
    endtask

    function automatic int rgap();
        if ($urandom_range(0, 9) == 0) return $urandom_range(17, 22);
        return $urandom_range(0, 2);
    endfunction

    task automatic rsend(input logic [7:0] b);
        step(1'b1, b);
        idle(rgap());
    endtask

    always @(negedge ipClk) begin
        if (chk_en) begin
            check("valid", 32'(rx_if.Valid), 32'(exp_cur.valid));
            check("sop", 32'(rx_if.SoP), 32'(exp_cur.sop));
            check("eop", 32'(rx_if.EoP), 32'(exp_cur.eop));
            check("data", 32'(rx_if.Data), 32'(exp_cur.data));
            check("dest", 32'(rx_if.Destination), 32'(exp_cur.dest));
            check("src", 32'(rx_if.Source), 32'(exp_cur.src));
            check("len", 32'(rx_if.Length), 32'(exp_cur.len));
            check("error", 32'(opError), 32'(exp_cur.err));
            check("busy", 32'(opBusy), 32'(exp_cur.busy));
        end
    end

    initial begin
        int         eb;
        int         erb;
        int         aa_step;
        logic [7:0] t1[4];
        logic [7:0] b;
        int         len;

        checks    = 0;
        errors    = 0;
        chk_en    = 1'b0;
        step_no   = 0;
        ipReset   = 1'b0;
        ipRxValid = 1'b0;
        ipRxData  = 8'h00;
        model_reset();

        repeat (3) @(posedge ipClk);
        #3;
        check("rst_valid", 32'(rx_if.Valid), 32'd0);
        check("rst_data", 32'(rx_if.Data), 32'd0);
        check("rst_dest", 32'(rx_if.Destination), 32'd0);
        check("rst_error", 32'(opError), 32'd0);
        check("rst_busy", 32'(opBusy), 32'd0);
        @(posedge ipClk);
        #1;
        ipReset = 1'b1;
        chk_en  = 1'b1;

        // Basic 4-byte frame
        eb = ev_q.size();
        t1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        bq = {8'h55, 8'h00, 8'h10, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_bq();
        idle(3);
        check("t1_count", 32'(ev_q.size() - eb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_ev_data", 32'(ev_q[eb+i].data), 32'(t1[i]));
            check("t1_ev_sop", 32'(ev_q[eb+i].sop), (i == 0) ? 32'd1 : 32'd0);
            check("t1_ev_eop", 32'(ev_q[eb+i].eop), (i == 3) ? 32'd1 : 32'd0);
            check("t1_ev_hdr", {8'h0, ev_q[eb+i].dest, ev_q[eb+i].src, ev_q[eb+i].len}, 32'h00_00_10_04);
        end
        check("t1_busy", 32'(opBusy), 32'd0);

        // Leading garbage then single-byte frame
        eb = ev_q.size(); erb = err_q.size();
        bq = {8'h00, 8'hFF, 8'h12, 8'h55, 8'h00, 8'h10, 8'h01, 8'h7E};
        send_bq();
        idle(2);
        check("t2_count", 32'(ev_q.size() - eb), 32'd1);
        check("t2_ev", {22'h0, ev_q[eb].sop, ev_q[eb].eop, ev_q[eb].data}, {22'h0, 2'b11, 8'h7E});
        check("t2_noerr", 32'(err_q.size() - erb), 32'd0);

        // Zero length
        eb = ev_q.size(); erb = err_q.size();
        bq = {8'h55, 8'h00, 8'h10, 8'h00};
        send_bq();
        aa_step = step_no;
        idle(2);
        check("t3_err", 32'(err_q.size() - erb), 32'd1);
        check("t3_err_step", 32'(err_q[erb]), 32'(aa_step));
        check("t3_noev", 32'(ev_q.size() - eb), 32'd0);
        bq = {8'h55, 8'h01, 8'h02, 8'h01, 8'h5A};
        send_bq();
        idle(2);
        check("t3_next", 32'(ev_q.size() - eb), 32'd1);

        // Timeout mid-frame
        eb = ev_q.size(); erb = err_q.size();
        bq = {8'h55, 8'h00, 8'h10, 8'h03, 8'hAA};
        send_bq();
        aa_step = step_no;
        idle(25);
        check("t4_count", 32'(ev_q.size() - eb), 32'd1);
        check("t4_ev", {23'h0, ev_q[eb].sop, ev_q[eb].data}, {23'h0, 1'b1, 8'hAA});
        check("t4_err_step", 32'(err_q[erb]), 32'(aa_step + TMO));
        check("t4_busy", 32'(opBusy), 32'd0);
        bq = {8'h55, 8'h00, 8'h10, 8'h01, 8'h11};
        send_bq();
        idle(2);
        check("t4_next", 32'(ev_q.size() - eb), 32'd2);

        // Sync value inside data
        eb = ev_q.size();
        bq = {8'h55, 8'h01, 8'h02, 8'h02, 8'h55, 8'h66};
        send_bq();
        idle(2);
        check("t5_count", 32'(ev_q.size() - eb), 32'd2);
        check("t5_ev0", {22'h0, ev_q[eb].sop, ev_q[eb].eop, ev_q[eb].data}, {22'h0, 2'b10, 8'h55});
        check("t5_ev1", {22'h0, ev_q[eb+1].sop, ev_q[eb+1].eop, ev_q[eb+1].data}, {22'h0, 2'b01, 8'h66});

        // Asynchronous reset mid-frame
        bq = {8'h55, 8'h00, 8'h10, 8'h04, 8'h01, 8'h02};
        send_bq();
        idle(1);
        #2;
        ipReset = 1'b0;
        model_reset();
        #1;
        check("t6_valid", 32'(rx_if.Valid), 32'd0);
        check("t6_data", 32'(rx_if.Data), 32'd0);
        check("t6_hdr", {8'h0, rx_if.Destination, rx_if.Source, rx_if.Length}, 32'd0);
        check("t6_busy", 32'(opBusy), 32'd0);
        idle(3);
        ipReset = 1'b1;
        eb = ev_q.size();
        bq = {8'h33, 8'h44};
        send_bq();
        idle(2);
        check("t6_none", 32'(ev_q.size() - eb), 32'd0);
        bq = {8'h55, 8'h07, 8'h08, 8'h02, 8'hC1, 8'hC2};
        send_bq();
        idle(2);
        check("t6_fresh", 32'(ev_q.size() - eb), 32'd2);
        check("t6_dest", 32'(ev_q[eb].dest), 32'h07);

        // Randomized frames with gaps around the timeout boundary
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h55) b = 8'h56;
                rsend(b);
            end
            rsend(8'h55);
            rsend(8'($urandom_range(0, 255)));
            rsend(8'($urandom_range(0, 255)));
            len = $urandom_range(0, 6);
            rsend(8'(len));
            for (int k = 0; k < len; k++) rsend(8'($urandom_range(0, 255)));
        end
        idle(TMO + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_packet_parser.md
Name: uart_packet_parser

Overview:
- Upstream neighbour of the register read/write controllers.
- Consumes the raw byte stream from the UART receiver and frames it into the UART_PACKET stream, with SoP, EoP, Destination, Source, Length, Data and Valid.
- Controllers gate on Valid and Destination; this block guarantees those fields are coherent and held for the whole packet.
- Malformed or stalled frames are discarded, and this is flagged on an error strobe.

Parameters:
- SYNC_BYTE, 8'h55: start-of-frame marker byte.
- TIMEOUT_CYCLES, 50000: maximum ipClk cycles allowed between bytes inside a frame before abort. Minimum legal value is 2.

Ports:
- ipClk  input  1  system clock; all logic on its rising edge.
- ipReset  input  1  reset, asynchronous assert, active-low (0 = reset).
- ipRxData  input  8  received byte from UART RX.
- ipRxValid  input  1  one-cycle strobe; ipRxData is valid this cycle.
- opRxStream  output  UART_PACKET  framed packet stream to the controllers.
- opError  output  1  one-cycle pulse on frame abort (timeout or zero length).
- opBusy  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Frame format on the wire: SYNC_BYTE, Destination, Source, Length (1..255), then Length data bytes.
- Reset state (ipReset low, asynchronous):
  - state = IDLE.
  - opRxStream.Valid/SoP/EoP = 0.
  - Data/Destination/Source/Length = 8'h00.
  - opError = 0; data counter = 0; timeout counter = 0.
- Reset mid-frame: the frame is dropped immediately. Nothing is emitted after reset release until a new SYNC_BYTE arrives.
- States and transitions, each taken on a cycle with ipRxValid=1:
  - IDLE: if ipRxData == SYNC_BYTE, go to DEST. Any other byte is ignored and stays in IDLE; opError is not raised.
  - DEST: latch the byte into Destination; go to SRC.
  - SRC: latch the byte into Source; go to LEN.
  - LEN: if the byte == 0, pulse opError and go to IDLE. Otherwise latch Length, load counter = byte, and go to DATA.
  - DATA: on each byte:
    - Output for one cycle: Data = byte, Valid = 1.
    - SoP = 1 only when counter == Length (first byte).
    - EoP = 1 only when counter == 1 (last byte).
    - Decrement the counter. After the byte where counter == 1, go to IDLE.
- Single-byte frame (Length = 1): SoP and EoP are both 1 on the same Valid cycle.
- Latency: opRxStream.Valid rises exactly 1 cycle after the ipRxValid of the data byte. Header bytes produce no Valid.
- Valid/SoP/EoP are single-cycle pulses and return to 0 the following cycle.
- Destination, Source and Length hold their latched values from LEN until the next frame's DEST byte overwrites them. They are stable across all Valid cycles of a packet.
- A SYNC_BYTE value received in DEST/SRC/LEN/DATA is treated as ordinary data; there is no resynchronisation mid-frame.
- Timeout:
  - In any state other than IDLE, the counter increments every cycle without ipRxValid and clears on ipRxValid.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: pulse opError for 1 cycle, go to IDLE, clear the counter. No EoP is emitted for the truncated packet.
  - If ipRxValid coincides with the terminal count, the byte wins and there is no timeout.
- Counter widths:
  - Data counter: 8 bits.
  - Timeout counter: $clog2(TIMEOUT_CYCLES) bits; it must not wrap before the terminal compare.
- opError and Valid are never high in the same cycle.
- Back-to-back frames: a SYNC_BYTE on the cycle immediately after the last data byte is accepted.

Test Plan:
- Reset, then bytes 55,00,10,04,A1,B2,C3,D4 → four Valid pulses:
  - Data A1,B2,C3,D4 with Destination=00, Source=10, Length=04 on each.
  - SoP only on A1; EoP only on D4; opBusy low after D4.
- Leading garbage 00,FF,12 then 55,00,10,01,7E → no Valid or opError from the garbage; one Valid with Data=7E and SoP=EoP=1.
- Length zero: 55,00,10,00 → opError pulse 1 cycle after the 00 length byte; no Valid; state IDLE; the next valid frame parses normally.
- Timeout (TIMEOUT_CYCLES=20): 55,00,10,03,AA, then a 25-cycle gap → one Valid (AA, SoP=1); opError pulses at the 20th idle-cycle boundary; no EoP; opBusy drops. A following 55,… frame parses from scratch.
- Data byte equal to the sync value: 55,01,02,02,55,66 → Valid Data=55 (SoP), then Valid Data=66 (EoP); no resync.
- Reset asserted (ipReset=0) after the second data byte of a 4-byte frame → outputs zero asynchronously. After release, bytes 33,44 produce no Valid until a fresh 55 header.
